// File: rtl/writeback_stage_pkg.sv
// Shared encodings for the writeback stage: opcodes, load funct3 values,
// FSM states and load sizes.
package writeback_stage_pkg;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } wb_state_e;

  // funct3[1:0] of a load is its size; funct3[2] selects zero extension.
  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } load_size_e;

  function automatic logic load_f3_legal(input logic [2:0] f3, input int xlen);
    case (f3)
      F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: return 1'b1;
      F3_LD, F3_LWU:                       return xlen == 64;
      default:                             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/writeback_stage_load_align.sv
// Load data alignment: selects the addressed byte/half/word/double from the
// memory read word and sign- or zero-extends it to XLEN.
module load_align
  import writeback_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OFF_W = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0]  data_i,
  input  logic [OFF_W-1:0] off_i,
  input  load_size_e       size_i,
  input  logic             unsigned_i,
  output logic [XLEN-1:0]  data_o
);

  logic [OFF_W-1:0] lane;
  logic [XLEN-1:0]  shifted;
  logic [XLEN-1:0]  keep;
  logic             sign_bit;

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    lane     = '0;
    keep     = '1;
    sign_bit = 1'b0;
    shifted  = '0;
    case (size_i)
      SZ_B:    lane = off_i;
      SZ_H:    lane = off_i & ~OFF_W'(1);
      SZ_W:    lane = off_i & ~OFF_W'(3);
      default: lane = '0;
    endcase
    shifted = data_i >> {lane, 3'b000};
    case (size_i)
      SZ_B: begin
        keep     = XLEN'(8'hFF);
        sign_bit = shifted[7];
      end
      SZ_H: begin
        keep     = XLEN'(16'hFFFF);
        sign_bit = shifted[15];
      end
      SZ_W: begin
        keep     = XLEN'(32'hFFFF_FFFF);
        sign_bit = shifted[31];
      end
      default: begin
        keep     = '1;
        sign_bit = shifted[XLEN-1];
      end
    endcase
    data_o = (shifted & keep) | ((sign_bit && !unsigned_i) ? ~keep : '0);
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: retires one instruction per cycle, waits on load responses,
// drives the register-file write pulse and error/retire reporting.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int MEM_TIMEOUT = 16,
  parameter int RET_W       = 32,
  parameter int OFF_W       = $clog2(XLEN / 8)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instruction,
  input  logic [XLEN-1:0]  in_pc_plus_4,
  input  logic [XLEN-1:0]  in_alu_out,
  input  logic [XLEN-1:0]  in_immediate,
  input  logic [OFF_W-1:0] in_addr_lo,
  input  logic             flush,
  input  logic [XLEN-1:0]  mem_dout,
  input  logic             mem_dout_valid,
  output logic             wb_en,
  output logic [4:0]       wb_rd,
  output logic [XLEN-1:0]  wb_data,
  output logic             err_misaligned,
  output logic             err_timeout,
  output logic             err_illegal,
  output logic [RET_W-1:0] retire_count
);

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  wb_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       ld_rd_q, ld_rd_d;
  load_size_e       ld_size_q, ld_size_d;
  logic             ld_uns_q, ld_uns_d;
  logic [OFF_W-1:0] ld_off_q, ld_off_d;
  logic             wb_en_q, wb_en_d;
  logic [4:0]       wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]  wb_data_q, wb_data_d;
  logic             err_mis_q, err_mis_d;
  logic             err_to_q, err_to_d;
  logic             err_ill_q, err_ill_d;
  logic [RET_W-1:0] retire_q, retire_d;

  logic [XLEN-1:0]  load_data;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [4:0]       rd;
  load_size_e       size;
  logic             misaligned;
  logic             wr;
  logic [4:0]       wr_rd;
  logic [XLEN-1:0]  wr_val;

  assign opcode = in_instruction[6:0];
  assign rd     = in_instruction[11:7];
  assign funct3 = in_instruction[14:12];
  assign size   = load_size_e'(funct3[1:0]);

  always_comb begin
    case (size)
      SZ_H:    misaligned = in_addr_lo[0];
      SZ_W:    misaligned = in_addr_lo[1:0] != 2'b00;
      SZ_D:    misaligned = in_addr_lo != '0;
      default: misaligned = 1'b0;
    endcase
  end

  load_align #(.XLEN(XLEN), .OFF_W(OFF_W)) u_load_align (
    .data_i     (mem_dout),
    .off_i      (ld_off_q),
    .size_i     (ld_size_q),
    .unsigned_i (ld_uns_q),
    .data_o     (load_data)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ld_rd_d   = ld_rd_q;
    ld_size_d = ld_size_q;
    ld_uns_d  = ld_uns_q;
    ld_off_d  = ld_off_q;
    err_mis_d = 1'b0;
    err_to_d  = 1'b0;
    err_ill_d = 1'b0;
    wr        = 1'b0;
    wr_rd     = rd;
    wr_val    = '0;
    retire_d  = retire_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          case (opcode)
            OPC_OP_IMM, OPC_OP, OPC_AUIPC: begin
              wr     = 1'b1;
              wr_val = in_alu_out;
            end
            OPC_OP_IMM_32, OPC_OP_32: begin
              if (XLEN == 64) begin
                wr     = 1'b1;
                wr_val = in_alu_out;
              end else begin
                err_ill_d = 1'b1;
              end
            end
            OPC_LUI: begin
              wr     = 1'b1;
              wr_val = in_immediate;
            end
            OPC_JAL, OPC_JALR: begin
              wr     = 1'b1;
              wr_val = in_pc_plus_4;
            end
            OPC_STORE, OPC_BRANCH: retire_d = retire_q + 1'b1;
            OPC_LOAD: begin
              if (!load_f3_legal(funct3, XLEN)) begin
                err_ill_d = 1'b1;
              end else if (misaligned) begin
                err_mis_d = 1'b1;
              end else begin
                state_d   = ST_WAIT;
                cnt_d     = '0;
                ld_rd_d   = rd;
                ld_size_d = size;
                ld_uns_d  = funct3[2];
                ld_off_d  = in_addr_lo;
              end
            end
            default: err_ill_d = 1'b1;
          endcase
        end
      end
      default: begin
        // Flush outranks a same-cycle response; a response outranks timeout.
        if (flush) begin
          state_d = ST_IDLE;
        end else if (mem_dout_valid) begin
          wr      = 1'b1;
          wr_rd   = ld_rd_q;
          wr_val  = load_data;
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          err_to_d = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
    wb_en_d   = wr && (wr_rd != 5'd0);
    wb_rd_d   = wr ? wr_rd : wb_rd_q;
    wb_data_d = wr ? wr_val : wb_data_q;
    if (wr) retire_d = retire_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ld_rd_q   <= '0;
      ld_size_q <= SZ_B;
      ld_uns_q  <= 1'b0;
      ld_off_q  <= '0;
      wb_en_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
      err_mis_q <= 1'b0;
      err_to_q  <= 1'b0;
      err_ill_q <= 1'b0;
      retire_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ld_rd_q   <= ld_rd_d;
      ld_size_q <= ld_size_d;
      ld_uns_q  <= ld_uns_d;
      ld_off_q  <= ld_off_d;
      wb_en_q   <= wb_en_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
      err_mis_q <= err_mis_d;
      err_to_q  <= err_to_d;
      err_ill_q <= err_ill_d;
      retire_q  <= retire_d;
    end
  end

  assign in_ready       = state_q == ST_IDLE;
  assign wb_en          = wb_en_q;
  assign wb_rd          = wb_rd_q;
  assign wb_data        = wb_data_q;
  assign err_misaligned = err_mis_q;
  assign err_timeout    = err_to_q;
  assign err_illegal    = err_ill_q;
  assign retire_count   = retire_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage (XLEN=64, MEM_TIMEOUT=4): expected
// outputs are queued as each cycle is driven and checked after the edge.
module tb_writeback_stage;
  import writeback_stage_pkg::*;

  localparam int XLEN = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instruction;
  logic [XLEN-1:0]  in_pc_plus_4;
  logic [XLEN-1:0]  in_alu_out;
  logic [XLEN-1:0]  in_immediate;
  logic [2:0]       in_addr_lo;
  logic             flush;
  logic [XLEN-1:0]  mem_dout;
  logic             mem_dout_valid;
  logic             wb_en;
  logic [4:0]       wb_rd;
  logic [XLEN-1:0]  wb_data;
  logic             err_misaligned;
  logic             err_timeout;
  logic             err_illegal;
  logic [31:0]      retire_count;

  writeback_stage #(.XLEN(XLEN), .MEM_TIMEOUT(4), .RET_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_instruction (in_instruction),
    .in_pc_plus_4   (in_pc_plus_4),
    .in_alu_out     (in_alu_out),
    .in_immediate   (in_immediate),
    .in_addr_lo     (in_addr_lo),
    .flush          (flush),
    .mem_dout       (mem_dout),
    .mem_dout_valid (mem_dout_valid),
    .wb_en          (wb_en),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .err_misaligned (err_misaligned),
    .err_timeout    (err_timeout),
    .err_illegal    (err_illegal),
    .retire_count   (retire_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        en;
    logic [4:0]  rd;
    logic [63:0] data;
    logic        chk;
    logic        mis;
    logic        tout;
    logic        ill;
    logic [31:0] ret;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic [31:0] ret = 0;

  function automatic logic [31:0] ins(logic [6:0] op, logic [2:0] f3, logic [4:0] rd);
    return {17'b0, f3, rd, op};
  endfunction

  function automatic exp_t e_base(logic rdy, logic [31:0] r);
    exp_t e;
    e.rdy = rdy; e.en = 1'b0; e.rd = '0; e.data = '0; e.chk = 1'b0;
    e.mis = 1'b0; e.tout = 1'b0; e.ill = 1'b0; e.ret = r;
    return e;
  endfunction

  function automatic exp_t e_wr(logic [4:0] rd, logic [63:0] d, logic [31:0] r);
    exp_t e = e_base(1'b1, r);
    e.en = 1'b1; e.rd = rd; e.data = d; e.chk = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_err(logic mis, logic tout, logic ill, logic [31:0] r);
    exp_t e = e_base(1'b1, r);
    e.mis = mis; e.tout = tout; e.ill = ill;
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s vector %0d: observed %0h expected %0h", tag, vectors, obs, expv);
    end
  endtask

  task automatic tick(input exp_t e);
    exp_t got;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    vectors++;
    check("in_ready", 64'(in_ready), 64'(got.rdy));
    check("wb_en", 64'(wb_en), 64'(got.en));
    check("err_misaligned", 64'(err_misaligned), 64'(got.mis));
    check("err_timeout", 64'(err_timeout), 64'(got.tout));
    check("err_illegal", 64'(err_illegal), 64'(got.ill));
    check("retire_count", 64'(retire_count), 64'(got.ret));
    if (got.chk) begin
      check("wb_rd", 64'(wb_rd), 64'(got.rd));
      check("wb_data", wb_data, got.data);
    end
  endtask

  task automatic quiet();
    rst = 1'b0; in_valid = 1'b0; in_instruction = '0; in_pc_plus_4 = '0;
    in_alu_out = '0; in_immediate = '0; in_addr_lo = '0; flush = 1'b0;
    mem_dout = '0; mem_dout_valid = 1'b0;
  endtask

  task automatic accept(input logic [31:0] i, input logic [2:0] off);
    quiet();
    in_valid = 1'b1; in_instruction = i; in_addr_lo = off;
  endtask

  task automatic respond(input logic [63:0] d);
    quiet();
    mem_dout_valid = 1'b1; mem_dout = d;
  endtask

  initial begin
    exp_t rst_e;
    rst_e = e_base(1'b1, 0);
    rst_e.chk = 1'b1;

    quiet(); rst = 1'b1;
    tick(rst_e);
    tick(rst_e);

    // ALU write, then LB off=3 answered two cycles later.
    accept(ins(OPC_OP_IMM, 3'b000, 5), 0); in_alu_out = 64'h1234;
    ret++; tick(e_wr(5, 64'h1234, ret));
    accept(ins(OPC_LOAD, F3_LB, 6), 3);
    tick(e_base(1'b0, ret));
    quiet();
    tick(e_base(1'b0, ret));
    respond(64'h80FF_0000);
    ret++; tick(e_wr(6, 64'hFFFF_FFFF_FFFF_FF80, ret));

    // LHU answered at the earliest cycle.
    accept(ins(OPC_LOAD, F3_LHU, 7), 2);
    tick(e_base(1'b0, ret));
    respond(64'hBEEF_1234);
    ret++; tick(e_wr(7, 64'h0000_BEEF, ret));

    // Misaligned LW, then a stray response in IDLE.
    accept(ins(OPC_LOAD, F3_LW, 8), 1);
    tick(e_err(1, 0, 0, ret));
    respond(64'hDEAD);
    tick(e_base(1'b1, ret));

    // Timeout after four WAIT cycles; a late response is ignored.
    accept(ins(OPC_LOAD, F3_LW, 9), 0);
    tick(e_base(1'b0, ret));
    quiet();
    tick(e_base(1'b0, ret));
    tick(e_base(1'b0, ret));
    tick(e_base(1'b0, ret));
    tick(e_err(0, 1, 0, ret));
    respond(64'h1111);
    tick(e_base(1'b1, ret));
    accept(ins(OPC_OP_IMM, 3'b000, 10), 0); in_alu_out = 64'h55;
    ret++; tick(e_wr(10, 64'h55, ret));

    // JAL rd=0 retires silently; LUI; illegal opcode; STORE/BRANCH; JALR.
    accept(ins(OPC_JAL, 3'b000, 0), 0); in_pc_plus_4 = 64'h100;
    ret++; tick(e_base(1'b1, ret));
    accept(ins(OPC_LUI, 3'b000, 7), 0); in_immediate = 64'hABCD_E000;
    ret++; tick(e_wr(7, 64'hABCD_E000, ret));
    accept(ins(7'h7F, 3'b000, 3), 0);
    tick(e_err(0, 0, 1, ret));
    accept(ins(OPC_STORE, 3'b010, 4), 0);
    ret++; tick(e_base(1'b1, ret));
    accept(ins(OPC_BRANCH, 3'b000, 4), 0);
    ret++; tick(e_base(1'b1, ret));
    accept(ins(OPC_JALR, 3'b000, 1), 0); in_pc_plus_4 = 64'h2004;
    ret++; tick(e_wr(1, 64'h2004, ret));
    accept(ins(OPC_LOAD, 3'b111, 2), 0);
    tick(e_err(0, 0, 1, ret));

    // Flush beats a same-cycle response; flush in IDLE is harmless.
    accept(ins(OPC_LOAD, F3_LW, 11), 0);
    tick(e_base(1'b0, ret));
    respond(64'h9999); flush = 1'b1;
    tick(e_base(1'b1, ret));
    accept(ins(OPC_OP, 3'b000, 12), 0); in_alu_out = 64'h77; flush = 1'b1;
    ret++; tick(e_wr(12, 64'h77, ret));

    // Reset in the middle of a load.
    accept(ins(OPC_LOAD, F3_LD, 13), 0);
    tick(e_base(1'b0, ret));
    quiet(); rst = 1'b1;
    ret = 0; tick(rst_e);
    respond(64'h4242);
    tick(e_base(1'b1, ret));

    // 64-bit loads: LWU, LW sign extension, LD, misaligned LD.
    accept(ins(OPC_LOAD, F3_LWU, 14), 4);
    tick(e_base(1'b0, ret));
    respond(64'hF000_0000_0000_0000);
    ret++; tick(e_wr(14, 64'h0000_0000_F000_0000, ret));
    accept(ins(OPC_LOAD, F3_LW, 15), 4);
    tick(e_base(1'b0, ret));
    respond(64'h8000_0001_0000_0000);
    ret++; tick(e_wr(15, 64'hFFFF_FFFF_8000_0001, ret));
    accept(ins(OPC_LOAD, F3_LD, 16), 0);
    tick(e_base(1'b0, ret));
    respond(64'h0123_4567_89AB_CDEF);
    ret++; tick(e_wr(16, 64'h0123_4567_89AB_CDEF, ret));
    accept(ins(OPC_LOAD, F3_LD, 16), 4);
    tick(e_err(1, 0, 0, ret));

    // Response on the last WAIT cycle wins over the timeout.
    accept(ins(OPC_LOAD, F3_LBU, 17), 5);
    tick(e_base(1'b0, ret));
    quiet();
    tick(e_base(1'b0, ret));
    tick(e_base(1'b0, ret));
    tick(e_base(1'b0, ret));
    respond(64'h0000_9A00_0000_0000);
    ret++; tick(e_wr(17, 64'h9A, ret));
    quiet();
    tick(e_base(1'b1, ret));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Registered, parametrised writeback stage of the RISC-V core, placed between the memory stage and the register file. It accepts one retiring instruction per cycle through a valid/ready handshake and waits on a variable-latency data-memory response for loads. It aligns and extends load data by byte offset, and drives a single-cycle register-file write pulse. It also reports misaligned loads, memory timeouts and illegal opcodes, and counts retired instructions.

## Interface
Parameters:
- XLEN, 32, datapath width; legal values 32 or 64. With 64, LD (funct3 011) and LWU (funct3 110) are enabled.
- MEM_TIMEOUT, 16, maximum cycles spent waiting for a load response (≥1).
- RET_W, 32, width of the retired-instruction counter.

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  memory stage presents an instruction
- in_ready  out  1  stage can accept (state IDLE)
- in_instruction  in  32  full instruction word (opcode, funct3, rd)
- in_pc_plus_4  in  XLEN  link value for JAL/JALR
- in_alu_out  in  XLEN  ALU result (R/I-type, AUIPC)
- in_immediate  in  XLEN  U-immediate for LUI
- in_addr_lo  in  log2(XLEN/8)  byte offset of the load address
- flush  in  1  discard any in-flight load
- mem_dout  in  XLEN  data-memory read word
- mem_dout_valid  in  1  mem_dout valid this cycle
- wb_en  out  1  register-file write strobe, one cycle per write
- wb_rd  out  5  destination register
- wb_data  out  XLEN  write data
- err_misaligned  out  1  one-cycle pulse
- err_timeout  out  1  one-cycle pulse
- err_illegal  out  1  one-cycle pulse, unknown opcode/funct3
- retire_count  out  RET_W  retired instructions, wraps modulo 2^RET_W

## Operation
- States: IDLE, WAIT. Acceptance happens when in_valid && in_ready.
- Acceptance in IDLE:
  - R/I-type and AUIPC write alu_out.
  - LUI writes immediate.
  - JAL/JALR write pc_plus_4.
  - STORE/BRANCH write nothing.
  - Aligned load: latch rd, funct3 and addr_lo, then go to WAIT.
- Write suppression: wb_en is asserted only if the instruction writes and rd≠0. The data is still computed.
- Load extraction from mem_dout:
  - Byte: mem_dout[8·off +: 8].
  - Half: [16·off[..1] +: 16].
  - Word: [32·off[..2] +: 32].
  - Double: the full word.
  - LB/LH/LW are sign-extended to XLEN. LBU/LHU/LWU are zero-extended.
- Misalignment: H with off[0]≠0, W with off[1:0]≠0, D with off≠0. Pulse err_misaligned, no write, no WAIT, no retire.
- Unknown opcode, or an unknown funct3 on a load: pulse err_illegal, no write, no retire.
- WAIT: first mem_dout_valid → write, retire, return to IDLE.
- WAIT timeout: the cycle counter reaching MEM_TIMEOUT−1 without valid → pulse err_timeout, no write, return to IDLE.
- Retire: retire_count increments once per instruction that completes without an error, including rd=0 and STORE/BRANCH.
- Boundary rules:
  - mem_dout_valid in IDLE is ignored.
  - Valid and timeout in the same cycle: valid wins.
  - flush in WAIT returns to IDLE with no write and no retire. Flush beats a same-cycle valid.
  - flush in IDLE has no effect on an instruction accepted that cycle.
  - rst mid-WAIT abandons the load.

## Timing
- Reset values: all outputs 0 except in_ready=1; state IDLE; timeout counter 0; retire_count 0.
- in_ready is a function of state only (no combinational path from in_valid).
- Non-load latency: wb_en/err pulse in the cycle after acceptance. Throughput is one per cycle.
- Load latency: write occurs in the cycle after mem_dout_valid. The earliest valid is the cycle after acceptance.
- in_ready is low for the whole WAIT, and high in the cycle the write appears.
- WAIT lasts at most MEM_TIMEOUT cycles. err_timeout appears in the cycle after the last WAIT cycle.
- All outputs are registered. wb_en and err_* are single-cycle pulses.

## Structure
- Opcode and funct3 constants come from the existing shared Opcode.vh.
- Add to the shared package/header:
  - the state encoding (IDLE, WAIT);
  - the load-size encoding;
  - the LD/LWU funct3 constants.
- Sub-module `load_align`: combinational offset-select plus sign/zero extension, parametrised by XLEN. It is instantiated once.

## Test plan
- ADDI, rd=5, alu_out=0x00001234 → next cycle wb_en=1, wb_rd=5, wb_data=0x00001234, retire_count=1.
- LB, off=3; mem_dout_valid two cycles later with 0x80FF0000 → in_ready low for 2 cycles, then wb_data=0xFFFFFF80. LHU, off=2, 0xBEEF1234 → 0x0000BEEF.
- LW, off=1 → err_misaligned pulse, wb_en=0, retire_count unchanged. A later stray mem_dout_valid is ignored.
- MEM_TIMEOUT=4, load with no response → err_timeout after 4 WAIT cycles. A valid on cycle 5 is ignored. The next ADDI is accepted normally.
- JAL rd=0 → wb_en=0, retire increments. LUI rd=7, imm=0xABCDE000 → wb_data=0xABCDE000. Opcode 0x7F → err_illegal.
- flush together with mem_dout_valid in WAIT → no write. rst during WAIT → all outputs reset, in_ready=1. XLEN=64, LWU off=4, mem 0xF0000000_00000000 → 0x00000000_F0000000.
